// File: rtl/uart_rx_frame_dispatcher_pkg.sv
// Shared types for the UART RX frame dispatcher: FSM states, FIFO entry layout, default sync marker.
package uart_pkg;

   localparam int                        UART_DATA_BITS = 8;
   localparam int                        UART_CHAN_W    = 2;
   localparam logic [UART_DATA_BITS-1:0] UART_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      HUNT,
      CHAN,
      LEN,
      PAYLOAD,
      CSUM,
      DISCARD
   } rx_frame_state_t;

   typedef struct packed {
      logic                      last;
      logic [UART_CHAN_W-1:0]    chan;
      logic [UART_DATA_BITS-1:0] data;
   } rx_frame_entry_t;

endpackage

// File: rtl/uart_rx_commit_fifo.sv
// Payload FIFO with a commit pointer between write and read: entries past the commit pointer are
// speculative and invisible to the consumer until committed, or discarded by a rollback.
module uart_rx_commit_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_push,
   input  rx_frame_entry_t             i_push_entry,
   input  logic                        i_pop,
   input  logic                        i_commit,
   input  logic                        i_rollback,
   output rx_frame_entry_t             o_head,
   output logic                        o_empty,
   output logic [$clog2(FIFO_DEPTH):0] o_free
);

   localparam int              AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     DEPTH_V = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]     ONE     = (AW+1)'(1);

   rx_frame_entry_t r_mem [FIFO_DEPTH];
   logic [AW:0]     r_wr;
   logic [AW:0]     r_cm;
   logic [AW:0]     r_rd;
   logic [AW:0]     w_wr_next;

   assign w_wr_next = i_push ? (r_wr + ONE) : r_wr;

   // Commit publishes this cycle's push too, so a byte can become visible on its own strobe edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr <= '0;
         r_cm <= '0;
         r_rd <= '0;
      end else begin
         r_wr <= i_rollback ? r_cm : w_wr_next;
         if (i_commit)
            r_cm <= w_wr_next;
         if (i_pop && !o_empty)
            r_rd <= r_rd + ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push)
         r_mem[r_wr[AW-1:0]] <= i_push_entry;
   end

   assign o_empty = (r_cm == r_rd);
   assign o_head  = r_mem[r_rd[AW-1:0]];
   assign o_free  = DEPTH_V - (r_wr - r_rd);

endmodule

// File: rtl/uart_rx_frame_dispatcher.sv
// Frames the UART RX byte stream (SYNC, CHAN, LEN, payload[, CSUM]) into a tagged valid/ready stream.
// Define UART_RX_CHECKSUM_EN to add the CSUM byte with speculative payload writes and rollback.
module uart_rx_frame_dispatcher
   import uart_pkg::*;
#(
   parameter int                   DATA_BITS    = UART_DATA_BITS,
   parameter int                   NUM_CHANNELS = 4,
   parameter int                   FIFO_DEPTH   = 16,
   parameter int                   MAX_LEN      = 16,
   parameter logic [DATA_BITS-1:0] SYNC_BYTE    = UART_SYNC_BYTE
) (
   input  logic                            Clock,
   input  logic                            ResetN,
   input  logic                            RxReady,
   input  logic [DATA_BITS-1:0]            RxData,
   output logic                            OutValid,
   input  logic                            OutReady,
   output logic [DATA_BITS-1:0]            OutData,
   output logic [$clog2(NUM_CHANNELS)-1:0] OutChannel,
   output logic                            OutLast,
   output logic                            FrameError,
   output logic                            Overflow,
   output logic                            Busy
);

   localparam int                   CHAN_W = $clog2(NUM_CHANNELS);
   localparam int                   CNT_W  = DATA_BITS + 1;
   localparam int                   FREE_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_BITS-1:0] NCH_B  = DATA_BITS'(NUM_CHANNELS);
   localparam logic [DATA_BITS-1:0] MAXL_B = DATA_BITS'(MAX_LEN);
   localparam logic [CNT_W-1:0]     CNT_1  = CNT_W'(1);

   rx_frame_state_t    r_state, w_state_n;
   logic [CNT_W-1:0]   r_count, w_count_n;
   logic [CHAN_W-1:0]  r_chan, w_chan_n;
   logic               r_ferr, w_ferr_n;
   logic               r_ovf, w_ovf_n;
   logic               w_push, w_pop, w_commit, w_rollback, w_empty;
   logic [FREE_W-1:0]  w_free;
   rx_frame_entry_t    w_push_entry, w_head;
`ifdef UART_RX_CHECKSUM_EN
   logic [DATA_BITS-1:0] r_sum, w_sum_n, w_csum_chk;
   assign w_csum_chk = r_sum + RxData;
`endif

   assign w_push_entry = '{last: (r_count == CNT_1), chan: r_chan, data: RxData};

   always_comb begin
      w_state_n  = r_state;
      w_count_n  = r_count;
      w_chan_n   = r_chan;
      w_ferr_n   = 1'b0;
      w_ovf_n    = 1'b0;
      w_push     = 1'b0;
      w_commit   = 1'b0;
      w_rollback = 1'b0;
`ifdef UART_RX_CHECKSUM_EN
      w_sum_n    = r_sum;
`endif
      if (RxReady) begin
         case (r_state)
            HUNT: begin
               if (RxData == SYNC_BYTE) begin
                  w_state_n = CHAN;
`ifdef UART_RX_CHECKSUM_EN
                  w_sum_n   = '0;
`endif
               end
            end
            CHAN: begin
               if (RxData >= NCH_B) begin
                  w_ferr_n  = 1'b1;
                  w_state_n = HUNT;
               end else begin
                  w_chan_n  = RxData[CHAN_W-1:0];
                  w_state_n = LEN;
`ifdef UART_RX_CHECKSUM_EN
                  w_sum_n   = r_sum + RxData;
`endif
               end
            end
            LEN: begin
               if (RxData == '0 || RxData > MAXL_B) begin
                  w_ferr_n  = 1'b1;
                  w_state_n = HUNT;
               end else if (CNT_W'(w_free) < CNT_W'(RxData)) begin
                  // The whole frame, checksum included, is swallowed so the FSM resyncs cleanly.
                  w_ovf_n   = 1'b1;
                  w_state_n = DISCARD;
`ifdef UART_RX_CHECKSUM_EN
                  w_count_n = CNT_W'(RxData) + CNT_1;
`else
                  w_count_n = CNT_W'(RxData);
`endif
               end else begin
                  w_count_n = CNT_W'(RxData);
                  w_state_n = PAYLOAD;
`ifdef UART_RX_CHECKSUM_EN
                  w_sum_n   = r_sum + RxData;
`endif
               end
            end
            PAYLOAD: begin
               w_push    = 1'b1;
               w_count_n = r_count - CNT_1;
`ifdef UART_RX_CHECKSUM_EN
               w_sum_n   = r_sum + RxData;
               if (r_count == CNT_1)
                  w_state_n = CSUM;
`else
               w_commit  = 1'b1;
               if (r_count == CNT_1)
                  w_state_n = HUNT;
`endif
            end
`ifdef UART_RX_CHECKSUM_EN
            CSUM: begin
               if (w_csum_chk == '0) begin
                  w_commit   = 1'b1;
               end else begin
                  w_rollback = 1'b1;
                  w_ferr_n   = 1'b1;
               end
               w_state_n = HUNT;
            end
`endif
            DISCARD: begin
               w_count_n = r_count - CNT_1;
               if (r_count == CNT_1)
                  w_state_n = HUNT;
            end
            default: w_state_n = HUNT;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_state <= HUNT;
         r_count <= '0;
         r_chan  <= '0;
         r_ferr  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
         r_sum   <= '0;
`endif
      end else begin
         r_state <= w_state_n;
         r_count <= w_count_n;
         r_chan  <= w_chan_n;
         r_ferr  <= w_ferr_n;
         r_ovf   <= w_ovf_n;
`ifdef UART_RX_CHECKSUM_EN
         r_sum   <= w_sum_n;
`endif
      end
   end

   uart_rx_commit_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk        (Clock),
      .i_rst_n      (ResetN),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_commit     (w_commit),
      .i_rollback   (w_rollback),
      .o_head       (w_head),
      .o_empty      (w_empty),
      .o_free       (w_free)
   );

   // Head fields are gated so stale or unwritten RAM never shows on an idle stream.
   assign OutValid   = !w_empty;
   assign w_pop      = OutValid && OutReady;
   assign OutData    = OutValid ? w_head.data : '0;
   assign OutChannel = OutValid ? w_head.chan : '0;
   assign OutLast    = OutValid ? w_head.last : 1'b0;
   assign FrameError = r_ferr;
   assign Overflow   = r_ovf;
   assign Busy       = (r_state != HUNT);

endmodule

// File: tb/tb_uart_rx_frame_dispatcher.sv
// Scoreboard bench for uart_rx_frame_dispatcher; follows the UART_RX_CHECKSUM_EN setting of the build.
module tb_uart_rx_frame_dispatcher;

   logic       Clock = 1'b0;
   logic       ResetN = 1'b0;
   logic       RxReady = 1'b0;
   logic [7:0] RxData = 8'h00;
   logic       OutReady = 1'b0;
   logic       OutValid;
   logic [7:0] OutData;
   logic [1:0] OutChannel;
   logic       OutLast;
   logic       FrameError;
   logic       Overflow;
   logic       Busy;

   int          n_pass = 0;
   int          n_checks = 0;
   int          n_fe = 0;
   int          n_ov = 0;
   int          n_pop = 0;
   logic        valid_seen = 1'b0;
   logic [10:0] exp_q[$];
   logic [10:0] got, want;

   uart_rx_frame_dispatcher dut (
      .Clock      (Clock),
      .ResetN     (ResetN),
      .RxReady    (RxReady),
      .RxData     (RxData),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .OutData    (OutData),
      .OutChannel (OutChannel),
      .OutLast    (OutLast),
      .FrameError (FrameError),
      .Overflow   (Overflow),
      .Busy       (Busy)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RxReady = 1'b1;
      RxData  = b;
      @(posedge Clock);
      #1;
      RxReady = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && !OutValid) break;
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] ch, input logic [7:0] len,
                             input logic [7:0] seed, input bit deliver);
      logic [7:0] b;
`ifdef UART_RX_CHECKSUM_EN
      logic [7:0] sum;
      sum = ch + len;
`endif
      send_byte(8'hA5);
      send_byte(ch);
      send_byte(len);
      for (int i = 0; i < int'(len); i++) begin
         b = seed + 8'(i * 13);
         if (deliver) exp_q.push_back({(i == int'(len) - 1), ch[1:0], b});
`ifdef UART_RX_CHECKSUM_EN
         sum = sum + b;
`endif
         send_byte(b);
      end
`ifdef UART_RX_CHECKSUM_EN
      send_byte(8'h00 - sum);
`endif
   endtask

   task automatic test_reset();
      ResetN = 1'b0;
      idle(2);
      n_checks++; if (OutValid !== 1'b0) $display("FAIL rst_outvalid: got %b want 0", OutValid); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
      n_checks++; if (FrameError !== 1'b0) $display("FAIL rst_frameerror: got %b want 0", FrameError); else n_pass++;
      n_checks++; if (Overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", Overflow); else n_pass++;
      n_checks++; if ({OutLast, OutChannel, OutData} !== 11'h000)
         $display("FAIL rst_outputs: got %h want 000", {OutLast, OutChannel, OutData}); else n_pass++;
      ResetN = 1'b1;
      idle(1);
      n_checks++; if ({OutValid, Busy} !== 2'b00) $display("FAIL rst_release: got %b want 00", {OutValid, Busy}); else n_pass++;
   endtask

   task automatic test_basic_frame();
      int fe0, ov0, pop0;
      fe0 = n_fe; ov0 = n_ov; pop0 = n_pop;
      OutReady = 1'b1;
      send_byte(8'h00);
      send_byte(8'hFF);
      n_checks++; if (Busy !== 1'b0) $display("FAIL basic_garbage_busy: got %b want 0", Busy); else n_pass++;
      send_byte(8'hA5);
      n_checks++; if (Busy !== 1'b1) $display("FAIL basic_sync_busy: got %b want 1", Busy); else n_pass++;
      exp_q.push_back({1'b0, 2'd1, 8'h11});
      exp_q.push_back({1'b0, 2'd1, 8'h22});
      exp_q.push_back({1'b1, 2'd1, 8'h33});
      send_byte(8'h01); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h96);
      wait_drain();
      idle(2);
      n_checks++; if (exp_q.size() != 0) $display("FAIL basic_undelivered: got %0d left want 0", exp_q.size()); else n_pass++;
      n_checks++; if (n_pop - pop0 != 3) $display("FAIL basic_pops: got %0d want 3", n_pop - pop0); else n_pass++;
      n_checks++; if (n_fe != fe0 || n_ov != ov0)
         $display("FAIL basic_pulses: got fe=%0d ov=%0d want fe=%0d ov=%0d", n_fe, n_ov, fe0, ov0); else n_pass++;
   endtask

`ifdef UART_RX_CHECKSUM_EN
   task automatic test_bad_csum();
      int fe0;
      fe0 = n_fe;
      OutReady = 1'b1;
      valid_seen = 1'b0;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h97);
      idle(4);
      n_checks++; if (n_fe - fe0 != 1) $display("FAIL badcsum_frameerror: got %0d pulses want 1", n_fe - fe0); else n_pass++;
      n_checks++; if (valid_seen !== 1'b0) $display("FAIL badcsum_outvalid: got %b want 0", valid_seen); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL badcsum_busy: got %b want 0", Busy); else n_pass++;
   endtask

   task automatic test_commit_latency();
      OutReady = 1'b0;
      exp_q.push_back({1'b0, 2'd2, 8'h44});
      exp_q.push_back({1'b1, 2'd2, 8'h55});
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
      send_byte(8'h44); send_byte(8'h55);
      n_checks++; if (OutValid !== 1'b0) $display("FAIL commit_speculative: got %b want 0", OutValid); else n_pass++;
      send_byte(8'h63);
      n_checks++; if ({OutValid, OutLast, OutChannel, OutData} !== {1'b1, 1'b0, 2'd2, 8'h44})
         $display("FAIL commit_visible: got %h want %h", {OutValid, OutLast, OutChannel, OutData},
                  {1'b1, 1'b0, 2'd2, 8'h44}); else n_pass++;
      OutReady = 1'b1;
      wait_drain();
      n_checks++; if (exp_q.size() != 0) $display("FAIL commit_drain: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask
`else
   task automatic test_latency_nocsum();
      OutReady = 1'b0;
      exp_q.push_back({1'b0, 2'd1, 8'hAA});
      exp_q.push_back({1'b1, 2'd1, 8'hBB});
      exp_q.push_back({1'b1, 2'd1, 8'hCC});
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
      n_checks++; if (OutValid !== 1'b0) $display("FAIL lat_before: got %b want 0", OutValid); else n_pass++;
      send_byte(8'hAA);
      n_checks++; if ({OutValid, OutLast, OutChannel, OutData} !== {1'b1, 1'b0, 2'd1, 8'hAA})
         $display("FAIL lat_visible: got %h want %h", {OutValid, OutLast, OutChannel, OutData},
                  {1'b1, 1'b0, 2'd1, 8'hAA}); else n_pass++;
      send_byte(8'hBB);
      n_checks++; if (Busy !== 1'b0) $display("FAIL lat_end_busy: got %b want 0", Busy); else n_pass++;
      send_byte(8'hA5);
      n_checks++; if (Busy !== 1'b1) $display("FAIL lat_resync: got %b want 1", Busy); else n_pass++;
      send_byte(8'h01); send_byte(8'h01); send_byte(8'hCC);
      OutReady = 1'b1;
      wait_drain();
      n_checks++; if (exp_q.size() != 0) $display("FAIL lat_drain: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask
`endif

   task automatic test_bad_chan();
      int fe0;
      fe0 = n_fe;
      OutReady = 1'b1;
      send_byte(8'hA5); send_byte(8'h07);
      idle(2);
      n_checks++; if (n_fe - fe0 != 1) $display("FAIL badchan_frameerror: got %0d want 1", n_fe - fe0); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL badchan_busy: got %b want 0", Busy); else n_pass++;
      exp_q.push_back({1'b1, 2'd2, 8'h5A});
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h5A);
      send_byte(8'hA3);
      wait_drain();
      idle(2);
      n_checks++; if (exp_q.size() != 0) $display("FAIL badchan_followup: got %0d left want 0", exp_q.size()); else n_pass++;
      n_checks++; if (n_fe - fe0 != 1) $display("FAIL badchan_extra_err: got %0d want 1", n_fe - fe0); else n_pass++;
   endtask

   task automatic test_len_bounds();
      int fe0;
      fe0 = n_fe;
      OutReady = 1'b1;
      send_byte(8'hA5); send_byte(8'h04);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11);
      idle(2);
      n_checks++; if (n_fe - fe0 != 3) $display("FAIL len_bound_errors: got %0d want 3", n_fe - fe0); else n_pass++;
      send_frame(8'h03, 8'h10, 8'h30, 1'b1);
      wait_drain();
      idle(2);
      n_checks++; if (exp_q.size() != 0) $display("FAIL len_max_frame: got %0d left want 0", exp_q.size()); else n_pass++;
      n_checks++; if (n_fe - fe0 != 3) $display("FAIL len_max_err: got %0d want 3", n_fe - fe0); else n_pass++;
   endtask

   task automatic test_overflow();
      int ov0, pop0;
      ov0 = n_ov;
      OutReady = 1'b0;
      send_frame(8'h00, 8'h0A, 8'h10, 1'b1);
      idle(2);
      n_checks++; if (OutValid !== 1'b1) $display("FAIL ovf_first_commit: got %b want 1", OutValid); else n_pass++;
      n_checks++; if (n_ov != ov0) $display("FAIL ovf_early: got %0d want %0d", n_ov, ov0); else n_pass++;
      send_frame(8'h01, 8'h07, 8'hC0, 1'b0);
      idle(2);
      n_checks++; if (n_ov - ov0 != 1) $display("FAIL ovf_pulse: got %0d want 1", n_ov - ov0); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL ovf_discard_end: got %b want 0", Busy); else n_pass++;
      send_frame(8'h02, 8'h06, 8'h70, 1'b1);
      idle(2);
      n_checks++; if (n_ov - ov0 != 1) $display("FAIL ovf_exact_fit: got %0d want 1", n_ov - ov0); else n_pass++;
      pop0 = n_pop;
      OutReady = 1'b1;
      wait_drain();
      idle(2);
      n_checks++; if (n_pop - pop0 != 16) $display("FAIL ovf_drain_count: got %0d want 16", n_pop - pop0); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL ovf_drain_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      OutReady = 1'b0;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
      send_byte(8'hE1); send_byte(8'hE2);
      n_checks++; if (Busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", Busy); else n_pass++;
      ResetN = 1'b0;
      #1;
      n_checks++; if ({OutValid, Busy} !== 2'b00) $display("FAIL midrst_async: got %b want 00", {OutValid, Busy}); else n_pass++;
      idle(2);
      ResetN = 1'b1;
      idle(1);
      n_checks++; if ({OutValid, Busy} !== 2'b00) $display("FAIL midrst_after: got %b want 00", {OutValid, Busy}); else n_pass++;
      OutReady = 1'b1;
      send_frame(8'h01, 8'h04, 8'h51, 1'b1);
      wait_drain();
      idle(2);
      n_checks++; if (exp_q.size() != 0) $display("FAIL midrst_next_frame: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      fork
         forever begin
            @(negedge Clock);
            if (ResetN) begin
               if (FrameError) n_fe++;
               if (Overflow) n_ov++;
               if (OutValid) valid_seen = 1'b1;
               if (OutValid && OutReady) begin
                  got = {OutLast, OutChannel, OutData};
                  n_pop++;
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     $display("FAIL stream_unexpected: got %h want no output", got);
                  end else begin
                     want = exp_q.pop_front();
                     if (got !== want) $display("FAIL stream_entry: got %h want %h", got, want);
                     else n_pass++;
                  end
               end
            end
         end
      join_none

      test_reset();
      test_basic_frame();
`ifdef UART_RX_CHECKSUM_EN
      test_bad_csum();
      test_commit_latency();
`else
      test_latency_nocsum();
`endif
      test_bad_chan();
      test_len_bounds();
      test_overflow();
      test_reset_midframe();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
